mult_adder_pipe: RTL



---
 rtl/mult_adder_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mult_adder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mult_adder_pipe : pipelined window x kernel dot product + bias, ReLU, sat.
// Revision        : 1.0
// ============================================================================
module mult_adder_pipe #(
  parameter int MA_TREE_SIZE = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_WIDTH    = 32,
  parameter int SIGNED       = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [DATA_WIDTH*MA_TREE_SIZE-1:0]   in,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH*MA_TREE_SIZE-1:0]   kernel,
  input  logic [OUT_WIDTH-1:0]                 bias,
  input  logic                                 kernel_load,
  input  logic                                 relu_en,
  output logic [OUT_WIDTH-1:0]                 out,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int N     = MA_TREE_SIZE;
  localparam int D     = $clog2(MA_TREE_SIZE);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = (((PW + D) > OUT_WIDTH) ? (PW + D) : OUT_WIDTH) + 1;

  // Number of live elements at tree level l (level 0 = products).
  function automatic int lvl_cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  logic [ACC_W-1:0]          tree_q [0:D][0:N-1];
  logic [ACC_W-1:0]          tree_d [0:D][0:N-1];
  logic [D:0]                vld_q;
  logic [D:0]                relu_q;
  logic [DATA_WIDTH*N-1:0]   kern_q;
  logic [OUT_WIDTH-1:0]      bias_q;
  logic [OUT_WIDTH-1:0]      out_q;
  logic [OUT_WIDTH-1:0]      out_d;
  logic                      out_valid_q;
  logic                      adv;
  logic [ACC_W-1:0]          acc_sum;
  logic [ACC_W-OUT_WIDTH:0]  acc_upper;
  logic                      acc_neg;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out       = out_q;
  assign out_valid = out_valid_q;

  always_comb begin : tree_next
    logic [DATA_WIDTH-1:0]        a;
    logic [DATA_WIDTH-1:0]        b;
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic signed [PW-1:0]         ps;
    logic [PW-1:0]                pu;
    a  = '0;
    b  = '0;
    sa = '0;
    sb = '0;
    ps = '0;
    pu = '0;
    for (int l = 0; l <= D; l++) begin
      for (int i = 0; i < N; i++) begin
        tree_d[l][i] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      a = in[i*DATA_WIDTH +: DATA_WIDTH];
      b = kern_q[i*DATA_WIDTH +: DATA_WIDTH];
      if (SIGNED != 0) begin
        sa = $signed(a);
        sb = $signed(b);
        ps = PW'(sa) * PW'(sb);
        tree_d[0][i] = {{(ACC_W-PW){ps[PW-1]}}, ps};
      end else begin
        pu = PW'(a) * PW'(b);
        tree_d[0][i] = {{(ACC_W-PW){1'b0}}, pu};
      end
    end
    // Pairwise sums; an odd trailing element is forwarded unchanged.
    for (int l = 1; l <= D; l++) begin
      for (int i = 0; i < N / 2; i++) begin
        if (i < lvl_cnt(l - 1) / 2) begin
          tree_d[l][i] = tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
        end
      end
      if ((lvl_cnt(l - 1) % 2) == 1) begin
        tree_d[l][lvl_cnt(l - 1) / 2] = tree_q[l-1][lvl_cnt(l - 1) - 1];
      end
    end
  end

  assign acc_sum   = tree_q[D][0] + {{(ACC_W-OUT_WIDTH){bias_q[OUT_WIDTH-1]}}, bias_q};
  assign acc_neg   = acc_sum[ACC_W-1];
  assign acc_upper = acc_sum[ACC_W-1:OUT_WIDTH-1];

  always_comb begin
    out_d = acc_sum[OUT_WIDTH-1:0];
    if (SIGNED != 0) begin
      if (relu_q[D] && acc_neg) begin
        out_d = '0;
      end else if (!((&acc_upper) || !(|acc_upper))) begin
        out_d = acc_neg ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end else begin
      if (acc_neg) begin
        out_d = '0;
      end else if (|acc_sum[ACC_W-1:OUT_WIDTH]) begin
        out_d = '1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q       <= '0;
      relu_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      kern_q      <= '0;
      bias_q      <= '0;
      for (int l = 0; l <= D; l++) begin
        for (int i = 0; i < N; i++) begin
          tree_q[l][i] <= '0;
        end
      end
    end else begin
      // Kernel/bias load is independent of the stall state.
      if (kernel_load) begin
        kern_q <= kernel;
        bias_q <= bias;
      end
      if (adv) begin
        vld_q       <= {vld_q[D-1:0], in_valid};
        relu_q      <= {relu_q[D-1:0], relu_en};
        out_valid_q <= vld_q[D];
        out_q       <= out_d;
        for (int l = 0; l <= D; l++) begin
          for (int i = 0; i < N; i++) begin
            tree_q[l][i] <= tree_d[l][i];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
